// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: scan controller for a WIDTH-to-1 mux.
// On START it steps SEL through channels 0..WIDTH-1. For each channel it
// waits SETTLE cycles, then samples MUX_OUT into a shadow word. At the end
// of the scan the shadow word moves atomically into DATA and DONE pulses.
// Optional feature: define MUX_SCAN_PARITY_EN to add the registered PARITY
// output, which is the XOR reduction of the completed scan word.
module mux_scan_ctrl #(
  parameter int WIDTH  = 16,
  parameter int SELW   = 4,
  parameter int SETTLE = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             MUX_OUT,
  output logic [SELW-1:0]  SEL,
  output logic [WIDTH-1:0] DATA,
  output logic             BUSY,
  output logic             DONE
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic             PARITY
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2
  } state_t;

  // The SAMPLE state itself consumes one cycle per channel, so WAIT only
  // needs SETTLE cycles in total. Its counter therefore starts at
  // SETTLE-1 and leaves WAIT on reaching zero. This places the sample
  // for channel i exactly (i+1)*(SETTLE+1) edges after the accepting edge.
  localparam logic [3:0] CNT_LOAD = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  // With no settle time, WAIT is skipped entirely.
  localparam state_t FIRST_ST = (SETTLE == 0) ? ST_SAMPLE : ST_WAIT;

  localparam logic [SELW-1:0] LAST_SEL = SELW'(WIDTH - 1);

`ifdef MUX_SCAN_PARITY_EN
  // Even-parity helper over one scan word.
  function automatic logic calc_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  state_t           state_r, state_s;
  logic [SELW-1:0]  sel_r, sel_s;
  logic [3:0]       cnt_r, cnt_s;
  logic [WIDTH-1:0] shadow_r, shadow_s;
  logic [WIDTH-1:0] data_r, data_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [WIDTH-1:0] merged_s;
`ifdef MUX_SCAN_PARITY_EN
  logic             parity_r, parity_s;
`endif

  // State and output registers; reset aborts any scan and clears the result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r  <= ST_IDLE;
      sel_r    <= '0;
      cnt_r    <= 4'd0;
      shadow_r <= '0;
      data_r   <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      sel_r    <= sel_s;
      cnt_r    <= cnt_s;
      shadow_r <= shadow_s;
      data_r   <= data_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
`ifdef MUX_SCAN_PARITY_EN
      parity_r <= parity_s;
`endif
    end
  end

  // Next-state logic: accept START in IDLE, settle, sample, advance, finish.
  always_comb begin
    state_s  = state_r;
    sel_s    = sel_r;
    cnt_s    = cnt_r;
    shadow_s = shadow_r;
    data_s   = data_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
    parity_s = parity_r;
`endif
    // Shadow word with the current channel's sample merged in.
    merged_s        = shadow_r;
    merged_s[sel_r] = MUX_OUT;

    case (state_r)
      ST_IDLE: begin
        if (START) begin
          state_s = FIRST_ST;
          sel_s   = '0;
          cnt_s   = CNT_LOAD;
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
        end
      end

      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_SAMPLE;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end

      ST_SAMPLE: begin
        shadow_s = merged_s;
        if (sel_r == LAST_SEL) begin
          // Last channel: publish the whole word at once and return home.
          state_s = ST_IDLE;
          data_s  = merged_s;
          done_s  = 1'b1;
          busy_s  = 1'b0;
          sel_s   = '0;
`ifdef MUX_SCAN_PARITY_EN
          parity_s = calc_parity(merged_s);
`endif
        end else begin
          state_s = FIRST_ST;
          sel_s   = sel_r + 1'b1;
          cnt_s   = CNT_LOAD;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a quiet idle without a DONE.
        state_s = ST_IDLE;
        sel_s   = '0;
        cnt_s   = 4'd0;
        busy_s  = 1'b0;
      end
    endcase
  end

  assign SEL  = sel_r;
  assign DATA = data_r;
  assign BUSY = busy_r;
  assign DONE = done_r;
`ifdef MUX_SCAN_PARITY_EN
  assign PARITY = parity_r;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl. Instance u_dut uses the defaults
// (WIDTH=16, SETTLE=1); u_dut0 uses SETTLE=0. A behavioural 16:1 mux
// drives MUX_OUT from each instance's SEL.
module tb_mux_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start1;
  logic [15:0] in_vec, in1;
  logic        mux_out, mux_out1;
  logic [3:0]  sel, sel1;
  logic [15:0] data, data1;
  logic        busy, busy1, done, done1;
`ifdef MUX_SCAN_PARITY_EN
  logic        parity, parity1;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] d;
    logic        p;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  typedef struct {
    logic [15:0] in_v;
    logic [15:0] exp_d;
    logic        exp_p;
  } vec_t;
  vec_t tbl[6];

  logic [15:0] prev_data;

  always #5 clk = ~clk;

  assign mux_out  = in_vec[sel];
  assign mux_out1 = in1[sel1];

  mux_scan_ctrl #(.WIDTH(16), .SELW(4), .SETTLE(1)) u_dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .MUX_OUT(mux_out),
    .SEL(sel), .DATA(data), .BUSY(busy), .DONE(done)
`ifdef MUX_SCAN_PARITY_EN
    , .PARITY(parity)
`endif
  );

  mux_scan_ctrl #(.WIDTH(16), .SELW(4), .SETTLE(0)) u_dut0 (
    .CLK(clk), .RST_N(rst_n), .START(start1), .MUX_OUT(mux_out1),
    .SEL(sel1), .DATA(data1), .BUSY(busy1), .DONE(done1)
`ifdef MUX_SCAN_PARITY_EN
    , .PARITY(parity1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every DONE pops the expectation pushed when the scan started.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("scan_data", {16'd0, data}, {16'd0, mon_e.d});
`ifdef MUX_SCAN_PARITY_EN
        chk("parity", {31'd0, parity}, {31'd0, mon_e.p});
`endif
      end
    end
  end

  // One full scan on the default instance with per-cycle SEL/BUSY/DATA checks.
  task automatic do_scan(input logic [15:0] v, input logic [15:0] exp_d, input logic exp_p);
    int sel_err  = 0;
    int busy_err = 0;
    int hold_err = 0;
    exp_t e;
    @(negedge clk);
    in_vec = v;
    start  = 1'b1;
    e.d = exp_d;
    e.p = exp_p;
    exp_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (sel !== 4'(c / 2)) sel_err++;
      if (busy !== 1'b1 || done !== 1'b0) busy_err++;
      if (data !== prev_data) hold_err++;
    end
    chk("sel_walk", sel_err, 0);
    chk("busy_window", busy_err, 0);
    chk("data_hold", hold_err, 0);
    @(negedge clk);
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("sel_home", {28'd0, sel}, 32'd0);
    prev_data = exp_d;
    @(negedge clk);
    chk("done_once", {31'd0, done}, 32'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    int n_done;
    int s_err;
    exp_t e;

    tbl[0] = '{16'hA5C3, 16'hA5C3, 1'b0};
    tbl[1] = '{16'h0007, 16'h0007, 1'b1};
    tbl[2] = '{16'h0003, 16'h0003, 1'b0};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b0};
    tbl[4] = '{16'h0000, 16'h0000, 1'b0};
    tbl[5] = '{16'h8001, 16'h8001, 1'b0};

    // Reset held with START high.
    rst_n  = 1'b0;
    start  = 1'b1;
    start1 = 1'b1;
    in_vec = 16'hA5C3;
    in1    = 16'h8001;
    prev_data = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_sel", {28'd0, sel}, 32'd0);
    chk("rst_data", {16'd0, data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy0", {31'd0, busy1}, 32'd0);
    start  = 1'b0;
    start1 = 1'b0;
    rst_n  = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_scan_after_rst", {31'd0, busy}, 32'd0);

    // Table-driven scans.
    for (int i = 0; i < 6; i++) begin
      do_scan(tbl[i].in_v, tbl[i].exp_d, tbl[i].exp_p);
    end

    // Mid-scan START is ignored; START held in the DONE cycle chains a scan.
    @(negedge clk);
    in_vec = 16'hA5C3;
    start  = 1'b1;
    e.d = 16'hA5C3;
    e.p = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);                  // edge k
    #1 start = 1'b0;
    repeat (9) @(posedge clk);       // edge k+9
    #1 start = 1'b1;
    @(posedge clk);                  // edge k+10 samples the ignored request
    #1 start = 1'b0;
    found = -1;
    for (int n = 10; n < 45; n++) begin
      @(negedge clk);                // between edge k+n and k+n+1
      if (done === 1'b1) begin
        found = n;
        break;
      end
    end
    chk("retrigger_done_edge", found, 32);
    in_vec = 16'h0001;
    start  = 1'b1;
    e.d = 16'h0001;
    e.p = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);                  // accepting edge of the second scan
    #1 start = 1'b0;
    found = -1;
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        found = n;
        break;
      end
    end
    chk("b2b_done_edge", found, 32);
    n_done = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy === 1'b1 || done === 1'b1) n_done++;
    end
    chk("no_extra_scan", n_done, 0);

    // Reset in the middle of a scan.
    prev_data = 16'h0001;
    do_scan(16'hA5C3, 16'hA5C3, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);                  // edge k
    #1 start = 1'b0;
    repeat (10) @(posedge clk);      // edge k+10
    #1 chk("pre_rst_sel", {28'd0, sel}, 32'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", {28'd0, sel}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_data", {16'd0, data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    chk("no_done_after_abort", n_done, 0);
    chk("data_cleared", {16'd0, data}, 32'd0);
    prev_data = 16'h0000;

    // SETTLE=0 instance: SEL advances every cycle, result at edge k+16.
    @(negedge clk);
    in1    = 16'h8001;
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    s_err = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (sel1 !== 4'(c) || busy1 !== 1'b1 || done1 !== 1'b0) s_err++;
    end
    chk("s0_sel_walk", s_err, 0);
    @(negedge clk);
    chk("s0_done", {31'd0, done1}, 32'd1);
    chk("s0_data", {16'd0, data1}, 32'h0000_8001);
    chk("s0_busy_end", {31'd0, busy1}, 32'd0);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
